// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: owns the PC, walks FETCH/DECODE/EXEC/MEM/WRITE, counts retirements.
// Minimum 5 cycles/instruction; FETCH, EXEC and MEM stretch until their handshake completes.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        fetch_req,
    input  logic        fetch_ready,
    input  logic        exec_multi,
    input  logic        exec_done,
    input  logic        mem_read_enabled,
    input  logic        mem_write_enabled,
    output logic        mem_req,
    input  logic        mem_done,
    input  logic        is_jump_enabled,
    input  logic [31:0] jump_dest,
    input  logic        halt_req,
    output logic        commit,
    output logic        trap_misaligned,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        trap_q, trap_d;

    logic        mem_access;
    logic        jump_misaligned;
    logic [31:0] pc_next;

    // A combined read+write is a single data-memory request.
    assign mem_access      = mem_read_enabled | mem_write_enabled;
    assign jump_misaligned = is_jump_enabled && (jump_dest[1:0] != 2'b00);
    assign pc_next         = is_jump_enabled ? jump_dest : (pc_q + PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!exec_multi || exec_done) state_d = S_MEM;
            end
            S_MEM: begin
                if (!mem_access || mem_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                // A trapping jump still retires but leaves the PC on the offending instruction.
                retired_d = retired_q + 32'd1;
                if (jump_misaligned) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_next;
                    state_d = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign state           = state_q;
    assign pc              = pc_q;
    assign retired         = retired_q;
    assign trap_misaligned = trap_q;
    assign fetch_req       = (state_q == S_FETCH);
    assign mem_req         = (state_q == S_MEM) && mem_access;
    assign commit          = (state_q == S_WRITE);

endmodule
